// File: rtl/se_sram_srw_clr_if.sv
// se_sram_srw_clr_if
//   Access and status bundle for the se_sram_srw_clr single-port SRAM.
//   The master drives select, read_not_write, write_enable, address,
//   write_data and clear_request. The slave (the SRAM) drives busy,
//   data_out and data_valid.
//   LANES = DATA_WIDTH / LANE_WIDTH write-enable bits.
interface se_sram_srw_clr_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 8
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  select;
    logic                  read_not_write;
    logic [LANES-1:0]      write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  clear_request;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;

    modport master (
        output select, read_not_write, write_enable, address, write_data, clear_request,
        input  busy, data_out, data_valid
    );

    modport slave (
        input  select, read_not_write, write_enable, address, write_data, clear_request,
        output busy, data_out, data_valid
    );
endinterface

// File: rtl/se_sram_srw_clr.sv
// se_sram_srw_clr
//   Parametrised single-port synchronous SRAM. It performs one read or one
//   write per clock. Writes are masked per lane. An optional output register
//   adds one cycle of read latency. A clear engine writes CLEAR_VALUE to
//   every word, either after reset (CLEAR_ON_RESET) or when clear_request
//   is pulsed. While the clear runs, busy is high and all accesses are
//   dropped.
//
//   Ports:
//     sram_clock    rising-edge clock
//     sram_reset_n  asynchronous active-low reset (the array itself is not reset)
//     bus           se_sram_srw_clr_if.slave:
//                     select/read_not_write/write_enable/address/write_data
//                     request an access; clear_request starts a clear.
//                     busy reports a clear in progress.
//                     data_out/data_valid return read data. data_out holds
//                     between reads.

// One write-enable lane. It stores LANE_WIDTH bits of every word.
// Reads are combinational; the top registers the result.
module se_sram_srw_clr_lane #(
    parameter int ADDR_WIDTH = 16,
    parameter int LANE_WIDTH = 8
) (
    input  logic                  sram_clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LANE_WIDTH-1:0] wdata,
    output logic [LANE_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [LANE_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge sram_clock) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

module se_sram_srw_clr #(
    parameter int                        ADDR_WIDTH     = 16,
    parameter int                        DATA_WIDTH     = 8,
    parameter int                        LANE_WIDTH     = 8,
    parameter int                        OUT_REG        = 0,
    parameter int                        CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE    = '0
) (
    input  logic                 sram_clock,
    input  logic                 sram_reset_n,
    se_sram_srw_clr_if.slave     bus
);
    localparam int LANES  = DATA_WIDTH / LANE_WIDTH;
    // Number of valid-pipeline stages between the request edge and data_valid.
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  clearing;
    logic                  rd_req;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] mem_addr;

    logic [LANES-1:0][LANE_WIDTH-1:0] clear_word;
    logic [LANES-1:0][LANE_WIDTH-1:0] wr_word;
    logic [LANES-1:0][LANE_WIDTH-1:0] lane_wdata;
    logic [LANES-1:0][LANE_WIDTH-1:0] rd_word;
    logic [LANES-1:0]                 lane_we;

    logic [STAGES:1]       vld_pipe;
    logic [DATA_WIDTH-1:0] data_q;

    assign clearing   = (state_q == CLEAR);
    assign clear_word = CLEAR_VALUE;
    assign wr_word    = bus.write_data;

    // Accesses are qualified only in IDLE. An access that arrives together
    // with clear_request still completes, because state_q is still IDLE on
    // that edge.
    assign rd_req = !clearing && bus.select &&  bus.read_not_write;
    assign wr_req = !clearing && bus.select && !bus.read_not_write;

    // The clear engine owns the single port while it runs.
    assign mem_addr   = clearing ? clr_cnt_q  : bus.address;
    assign lane_wdata = clearing ? clear_word : wr_word;

    // ---------------- FSM ----------------
    always_ff @(posedge sram_clock or negedge sram_reset_n) begin
        if (!sram_reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clear_request) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter wraps to 0 on the last clear write. It is also held at 0
    // in IDLE, so every clear starts at address 0.
    always_ff @(posedge sram_clock or negedge sram_reset_n) begin
        if (!sram_reset_n) begin
            clr_cnt_q <= '0;
        end else if (clearing) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end else begin
            clr_cnt_q <= '0;
        end
    end

    // ---------------- storage lanes ----------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_we[i] = clearing || (wr_req && bus.write_enable[i]);

        se_sram_srw_clr_lane #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .LANE_WIDTH (LANE_WIDTH)
        ) u_lane (
            .sram_clock (sram_clock),
            .wr_en      (lane_we[i]),
            .addr       (mem_addr),
            .wdata      (lane_wdata[i]),
            .rdata      (rd_word[i])
        );
    end

    // ---------------- read return ----------------
    // The valid pipeline keeps advancing through a clear. A read that is
    // already in flight therefore still delivers its pulse.
    always_ff @(posedge sram_clock or negedge sram_reset_n) begin
        if (!sram_reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_req;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] stage_q;

        always_ff @(posedge sram_clock or negedge sram_reset_n) begin
            if (!sram_reset_n) begin
                stage_q <= '0;
                data_q  <= '0;
            end else begin
                if (rd_req)      stage_q <= rd_word;
                if (vld_pipe[1]) data_q  <= stage_q;
            end
        end
    end else begin : g_noreg
        always_ff @(posedge sram_clock or negedge sram_reset_n) begin
            if (!sram_reset_n) begin
                data_q <= '0;
            end else if (rd_req) begin
                data_q <= rd_word;
            end
        end
    end

    assign bus.busy       = clearing;
    assign bus.data_out   = data_q;
    assign bus.data_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_se_sram_srw_clr.sv
// Directed bench for se_sram_srw_clr. It uses three instances:
//   dut0: OUT_REG=0, CLEAR_ON_RESET=1
//   dut1: OUT_REG=1, CLEAR_ON_RESET=1
//   dut2: OUT_REG=0, CLEAR_ON_RESET=0
// All three share the same stimulus. Outputs are sampled on the falling edge.
module tb_se_sram_srw_clr;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam logic [15:0] CV = 16'hA5A5;

    logic        sram_clock = 1'b0;
    logic        sram_reset_n;
    logic        select;
    logic        read_not_write;
    logic [1:0]  write_enable;
    logic [3:0]  address;
    logic [15:0] write_data;
    logic        clear_request;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_mem [16];

    always #5 sram_clock = ~sram_clock;

    se_sram_srw_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) bus0 ();
    se_sram_srw_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) bus1 ();
    se_sram_srw_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) bus2 ();

    assign bus0.select = select;          assign bus1.select = select;          assign bus2.select = select;
    assign bus0.read_not_write = read_not_write;
    assign bus1.read_not_write = read_not_write;
    assign bus2.read_not_write = read_not_write;
    assign bus0.write_enable = write_enable;  assign bus1.write_enable = write_enable;  assign bus2.write_enable = write_enable;
    assign bus0.address = address;        assign bus1.address = address;        assign bus2.address = address;
    assign bus0.write_data = write_data;  assign bus1.write_data = write_data;  assign bus2.write_data = write_data;
    assign bus0.clear_request = clear_request;
    assign bus1.clear_request = clear_request;
    assign bus2.clear_request = clear_request;

    se_sram_srw_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .OUT_REG(0),
                      .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV))
        dut0 (.sram_clock(sram_clock), .sram_reset_n(sram_reset_n), .bus(bus0));
    se_sram_srw_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .OUT_REG(1),
                      .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV))
        dut1 (.sram_clock(sram_clock), .sram_reset_n(sram_reset_n), .bus(bus1));
    se_sram_srw_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .OUT_REG(0),
                      .CLEAR_ON_RESET(0), .CLEAR_VALUE(CV))
        dut2 (.sram_clock(sram_clock), .sram_reset_n(sram_reset_n), .bus(bus2));

    task automatic step();
        @(posedge sram_clock);
        @(negedge sram_clock);
    endtask

    task automatic drive_idle();
        select = 1'b0; read_not_write = 1'b0; write_enable = 2'b00;
        address = '0; write_data = '0; clear_request = 1'b0;
    endtask

    task automatic drive_read(input logic [3:0] a);
        drive_idle();
        select = 1'b1; read_not_write = 1'b1; address = a;
    endtask

    task automatic drive_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we);
        drive_idle();
        select = 1'b1; address = a; write_data = d; write_enable = we;
    endtask

    // Plan item 1: reset values, then busy high for exactly 16 cycles.
    task automatic test_reset();
        int cnt;
        sram_reset_n = 1'b0;
        drive_idle();
        @(negedge sram_clock); @(negedge sram_clock);
        vectors++; if (bus0.busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy0 got %b want 1", bus0.busy); end
        vectors++; if (bus1.busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy1 got %b want 1", bus1.busy); end
        vectors++; if (bus2.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy2 got %b want 0", bus2.busy); end
        vectors++; if (bus0.data_out !== 16'h0) begin miscompares++; $display("FAIL reset_dout0 got %h want 0000", bus0.data_out); end
        vectors++; if (bus1.data_out !== 16'h0) begin miscompares++; $display("FAIL reset_dout1 got %h want 0000", bus1.data_out); end
        vectors++; if (bus0.data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid0 got %b want 0", bus0.data_valid); end
        sram_reset_n = 1'b1;
        cnt = 0;
        while (bus0.busy === 1'b1 && cnt < 100) begin step(); cnt++; end
        vectors++; if (cnt != 16) begin miscompares++; $display("FAIL reset_clear_len got %0d want 16", cnt); end
        vectors++; if (bus1.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy1_end got %b want 0", bus1.busy); end
        for (int i = 0; i < 16; i++) exp_mem[i] = CV;
    endtask

    // Back-to-back reads of every address. dut0 returns each word one edge
    // after issue, and dut1 one edge later than dut0.
    task automatic test_back_to_back(input string tag);
        int p0, p1;
        p0 = 0; p1 = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive_read(i[3:0]); else drive_idle();
            step();
            if (i < 16) begin
                vectors++;
                if (bus0.data_valid !== 1'b1 || bus0.data_out !== exp_mem[i]) begin
                    miscompares++;
                    $display("FAIL %s_b2b0[%0d] got %b/%h want 1/%h", tag, i, bus0.data_valid, bus0.data_out, exp_mem[i]);
                end
                if (bus0.data_valid === 1'b1) p0++;
            end
            if (i > 0) begin
                vectors++;
                if (bus1.data_valid !== 1'b1 || bus1.data_out !== exp_mem[i-1]) begin
                    miscompares++;
                    $display("FAIL %s_b2b1[%0d] got %b/%h want 1/%h", tag, i-1, bus1.data_valid, bus1.data_out, exp_mem[i-1]);
                end
                if (bus1.data_valid === 1'b1) p1++;
            end
        end
        vectors++; if (bus0.data_valid !== 1'b0) begin miscompares++; $display("FAIL %s_b2b0_tail got %b want 0", tag, bus0.data_valid); end
        vectors++; if (p0 != 16 || p1 != 16) begin miscompares++; $display("FAIL %s_pulses got %0d/%0d want 16/16", tag, p0, p1); end
    endtask

    // Plan items 2 and 3: lane masking, read-after-write, and read latency.
    task automatic test_lane_write();
        drive_write(4'd3, 16'h1234, 2'b11); step();
        drive_write(4'd3, 16'hFFEE, 2'b01); step();
        drive_read(4'd3); step();
        vectors++; if (bus0.data_valid !== 1'b1 || bus0.data_out !== 16'h12EE) begin
            miscompares++; $display("FAIL lane_raw0 got %b/%h want 1/12ee", bus0.data_valid, bus0.data_out); end
        vectors++; if (bus1.data_valid !== 1'b0) begin
            miscompares++; $display("FAIL lane_lat1_early got %b want 0", bus1.data_valid); end
        drive_idle(); step();
        vectors++; if (bus1.data_valid !== 1'b1 || bus1.data_out !== 16'h12EE) begin
            miscompares++; $display("FAIL lane_lat1 got %b/%h want 1/12ee", bus1.data_valid, bus1.data_out); end
        vectors++; if (bus0.data_valid !== 1'b0 || bus0.data_out !== 16'h12EE) begin
            miscompares++; $display("FAIL lane_hold0 got %b/%h want 0/12ee", bus0.data_valid, bus0.data_out); end
        drive_write(4'd3, 16'h0000, 2'b00); step();
        drive_read(4'd3); step();
        vectors++; if (bus0.data_out !== 16'h12EE) begin
            miscompares++; $display("FAIL lane_we00 got %h want 12ee", bus0.data_out); end
        drive_idle(); step();
        exp_mem[3] = 16'h12EE;
    endtask

    // Plan item 4: read with clear_request, write and re-request during busy.
    task automatic test_clear_busy();
        int cnt;
        drive_read(4'd3); clear_request = 1'b1; step();
        vectors++; if (bus0.busy !== 1'b1 || bus0.data_valid !== 1'b1 || bus0.data_out !== 16'h12EE) begin
            miscompares++; $display("FAIL clr_access0 got %b/%b/%h want 1/1/12ee", bus0.busy, bus0.data_valid, bus0.data_out); end
        cnt = 0;
        while (bus0.busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 8) begin drive_write(4'd5, 16'h1111, 2'b11); clear_request = 1'b1; end
            else drive_idle();
            step();
            if (cnt == 1) begin
                vectors++; if (bus1.data_valid !== 1'b1 || bus1.data_out !== 16'h12EE) begin
                    miscompares++; $display("FAIL clr_inflight1 got %b/%h want 1/12ee", bus1.data_valid, bus1.data_out); end
            end
        end
        vectors++; if (cnt != 16) begin miscompares++; $display("FAIL clr_busy_len got %0d want 16", cnt); end
        for (int i = 0; i < 16; i++) exp_mem[i] = CV;
    endtask

    // Plan item 6: data_out holds and data_valid stays low while select=0.
    task automatic test_select_low();
        drive_write(4'd9, 16'h9C3B, 2'b11); step();
        drive_read(4'd9); step();
        vectors++; if (bus0.data_out !== 16'h9C3B) begin
            miscompares++; $display("FAIL sel_setup got %h want 9c3b", bus0.data_out); end
        for (int k = 0; k < 5; k++) begin
            drive_idle(); read_not_write = 1'b1; address = k[3:0];
            step();
            vectors++; if (bus0.data_valid !== 1'b0 || bus0.data_out !== 16'h9C3B) begin
                miscompares++; $display("FAIL sel_hold0[%0d] got %b/%h want 0/9c3b", k, bus0.data_valid, bus0.data_out); end
            vectors++; if (bus1.data_valid !== (k == 0) || bus1.data_out !== 16'h9C3B) begin
                miscompares++; $display("FAIL sel_hold1[%0d] got %b/%h want %0d/9c3b", k, bus1.data_valid, bus1.data_out, k == 0); end
        end
        exp_mem[9] = 16'h9C3B;
    endtask

    // Plan item 5: reset at cycle 7 of a clear.
    task automatic test_reset_mid_clear();
        int cnt;
        drive_idle(); clear_request = 1'b1; step();
        drive_idle();
        repeat (7) step();
        sram_reset_n = 1'b0;
        #1;
        vectors++; if (bus0.data_out !== 16'h0 || bus0.data_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_rst_out0 got %b/%h want 0/0000", bus0.data_valid, bus0.data_out); end
        vectors++; if (bus1.data_out !== 16'h0) begin
            miscompares++; $display("FAIL mid_rst_out1 got %h want 0000", bus1.data_out); end
        vectors++; if (bus0.busy !== 1'b1 || bus2.busy !== 1'b0) begin
            miscompares++; $display("FAIL mid_rst_busy got %b/%b want 1/0", bus0.busy, bus2.busy); end
        @(negedge sram_clock);
        sram_reset_n = 1'b1;
        cnt = 0;
        while (bus0.busy === 1'b1 && cnt < 100) begin
            step(); cnt++;
            vectors++; if (bus2.busy !== 1'b0) begin
                miscompares++; $display("FAIL mid_rst_busy2[%0d] got %b want 0", cnt, bus2.busy); end
        end
        vectors++; if (cnt != 16) begin miscompares++; $display("FAIL mid_rst_clear_len got %0d want 16", cnt); end
        drive_read(4'd9); step();
        vectors++; if (bus2.data_valid !== 1'b1 || bus2.data_out !== 16'h9C3B) begin
            miscompares++; $display("FAIL noclr_retain got %b/%h want 1/9c3b", bus2.data_valid, bus2.data_out); end
        vectors++; if (bus0.data_out !== CV) begin
            miscompares++; $display("FAIL mid_rst_recleared got %h want a5a5", bus0.data_out); end
        drive_read(4'd0); step();
        vectors++; if (bus2.data_out !== CV) begin
            miscompares++; $display("FAIL noclr_partial got %h want a5a5", bus2.data_out); end
        drive_idle(); step();
        for (int i = 0; i < 16; i++) exp_mem[i] = CV;
    endtask

    initial begin
        test_reset();
        test_back_to_back("clear");
        test_lane_write();
        test_back_to_back("lanes");
        test_clear_busy();
        test_back_to_back("reclear");
        test_select_low();
        test_reset_mid_clear();
        test_back_to_back("rst_clear");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
